// File: rtl/writeback_stage_pkg.sv
// Constants and types shared by the writeback stage, its interface and its sub-module.
package writeback_stage_pkg;

  localparam int WIDTH          = 32;
  localparam int BYTE           = 8;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int LINK_OFFSET    = 8;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2,
    WB_LINK = 2'd3
  } wb_kind_t;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_FULL = 2'd3
  } load_size_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB instruction bus with a valid/ready handshake.
interface writeback_stage_if #(
  parameter int WIDTH          = writeback_stage_pkg::WIDTH,
  parameter int REG_ADDR_WIDTH = writeback_stage_pkg::REG_ADDR_WIDTH
) ();
  import writeback_stage_pkg::*;

  localparam int OFFSET_W = $clog2(WIDTH / 8);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_pc;
  logic                      in_rd;
  logic [REG_ADDR_WIDTH-1:0] in_rd_address;
  wb_kind_t                  in_kind;
  load_size_t                in_load_size;
  logic                      in_load_signed;
  logic [OFFSET_W-1:0]       in_byte_offset;
  logic [WIDTH-1:0]          in_alu_result;

  modport master (
    output in_valid, in_pc, in_rd, in_rd_address, in_kind,
           in_load_size, in_load_signed, in_byte_offset, in_alu_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_address, in_kind,
           in_load_size, in_load_signed, in_byte_offset, in_alu_result,
    output in_ready
  );

endinterface

// File: rtl/writeback_stage_load_extract.sv
// Little-endian lane select of a sub-word load plus sign/zero extension.
module writeback_stage_load_extract #(
  parameter int WIDTH = writeback_stage_pkg::WIDTH,
  localparam int OFFSET_W = $clog2(WIDTH / 8)
) (
  input  logic [WIDTH-1:0]              data,
  input  writeback_stage_pkg::load_size_t size,
  input  logic                          sign_ext,
  input  logic [OFFSET_W-1:0]           offset,
  output logic [WIDTH-1:0]              result
);
  import writeback_stage_pkg::*;

  logic [OFFSET_W-1:0] lane_off;
  logic [WIDTH-1:0]    keep_mask;
  logic [WIDTH-1:0]    shifted;
  logic                sign_bit;

  // Align the selected lane to bit 0, then mask and extend it.
  always_comb begin
    lane_off  = '0;
    keep_mask = '1;
    sign_bit  = 1'b0;
    // Lower offset bits inside a wider lane are ignored; alignment is trapped upstream.
    case (size)
      LS_BYTE: begin
        lane_off  = offset;
        keep_mask = WIDTH'({BYTE{1'b1}});
      end
      LS_HALF: begin
        lane_off  = offset & ~OFFSET_W'(1);
        keep_mask = WIDTH'({(2 * BYTE){1'b1}});
      end
      LS_WORD: begin
        lane_off  = offset & ~OFFSET_W'(3);
        keep_mask = WIDTH'({(4 * BYTE){1'b1}});
      end
      default: begin
        lane_off  = '0;
        keep_mask = '1;
      end
    endcase
    shifted = data >> {lane_off, 3'b000};
    case (size)
      LS_BYTE: sign_bit = shifted[BYTE-1];
      LS_HALF: sign_bit = shifted[2*BYTE-1];
      LS_WORD: sign_bit = shifted[4*BYTE-1];
      default: sign_bit = shifted[WIDTH-1];
    endcase
    result = (shifted & keep_mask) | ((sign_ext && sign_bit) ? ~keep_mask : '0);
  end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB stage: accepts one instruction per cycle, waits for late load
// data with a bounded timeout, and drives the register-file write port and retire strobe.
//
// state       | meaning
// ------------|---------------------------------------------------------------
// S_IDLE      | ready for a new instruction; non-waiting results retire next cycle
// S_WAIT_LOAD | load accepted without data; holding its fields until data, flush or timeout
module writeback_stage #(
  parameter int WIDTH          = writeback_stage_pkg::WIDTH,
  parameter int REG_ADDR_WIDTH = writeback_stage_pkg::REG_ADDR_WIDTH,
  parameter int LOAD_TIMEOUT   = 15,
  localparam int OFFSET_W      = $clog2(WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  writeback_stage_if.slave          mem,
  input  logic                      load_data_valid,
  input  logic [WIDTH-1:0]          load_data,
  input  logic                      flush,
  output logic                      rd_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_address_wb,
  output logic [WIDTH-1:0]          rd_data_wb,
  output logic [WIDTH-1:0]          pc_wb,
  output logic                      retire_wb,
  output logic                      load_timeout_err
);
  import writeback_stage_pkg::*;

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      ready_q;

  logic [WIDTH-1:0]          hold_pc;
  logic                      hold_rd;
  logic [REG_ADDR_WIDTH-1:0] hold_addr;
  load_size_t                hold_size;
  logic                      hold_signed;
  logic [OFFSET_W-1:0]       hold_offset;

  logic                      capture;
  logic                      retire;
  logic                      timeout;
  logic                      ret_rd_en;
  logic [REG_ADDR_WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0]          ret_pc;
  logic [WIDTH-1:0]          ret_data;

  load_size_t                ext_size;
  logic                      ext_signed;
  logic [OFFSET_W-1:0]       ext_offset;
  logic [WIDTH-1:0]          ext_result;

  // Ready comes from a flop so load_data_valid never reaches in_ready combinationally.
  assign mem.in_ready = ready_q;

  // A waiting load extracts with its held fields; otherwise the offered instruction's.
  assign ext_size   = (state == S_WAIT_LOAD) ? hold_size   : mem.in_load_size;
  assign ext_signed = (state == S_WAIT_LOAD) ? hold_signed : mem.in_load_signed;
  assign ext_offset = (state == S_WAIT_LOAD) ? hold_offset : mem.in_byte_offset;

  writeback_stage_load_extract #(.WIDTH(WIDTH)) u_load_extract (
    .data     (load_data),
    .size     (ext_size),
    .sign_ext (ext_signed),
    .offset   (ext_offset),
    .result   (ext_result)
  );

  // State, timeout counter and ready flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == S_IDLE);
    end
  end

  // Next state and the retirement decision; flush outranks everything else.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    retire    = 1'b0;
    timeout   = 1'b0;
    ret_rd_en = 1'b0;
    ret_addr  = hold_addr;
    ret_pc    = hold_pc;
    ret_data  = '0;
    case (state)
      S_IDLE: begin
        if (!flush && mem.in_valid && ready_q) begin
          if (mem.in_kind == WB_LOAD && !load_data_valid) begin
            capture   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_WAIT_LOAD;
          end else begin
            retire    = 1'b1;
            ret_pc    = mem.in_pc;
            ret_addr  = mem.in_rd_address;
            ret_rd_en = mem.in_rd && (mem.in_kind != WB_NONE);
            case (mem.in_kind)
              WB_ALU:  ret_data = mem.in_alu_result;
              WB_LINK: ret_data = mem.in_pc + WIDTH'(LINK_OFFSET);
              WB_LOAD: ret_data = ext_result;
              default: ret_data = '0;
            endcase
          end
        end
      end
      S_WAIT_LOAD: begin
        if (flush) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (load_data_valid) begin
          retire    = 1'b1;
          ret_rd_en = hold_rd;
          ret_data  = ext_result;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
          retire    = 1'b1;
          timeout   = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Hold registers for a load whose data has not arrived yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pc     <= '0;
      hold_rd     <= 1'b0;
      hold_addr   <= '0;
      hold_size   <= LS_BYTE;
      hold_signed <= 1'b0;
      hold_offset <= '0;
    end else if (capture) begin
      hold_pc     <= mem.in_pc;
      hold_rd     <= mem.in_rd;
      hold_addr   <= mem.in_rd_address;
      hold_size   <= mem.in_load_size;
      hold_signed <= mem.in_load_signed;
      hold_offset <= mem.in_byte_offset;
    end
  end

  // Output registers: strobes pulse for one cycle, address/data/pc hold between retirements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wb            <= 1'b0;
      retire_wb        <= 1'b0;
      load_timeout_err <= 1'b0;
      rd_address_wb    <= '0;
      rd_data_wb       <= '0;
      pc_wb            <= '0;
    end else begin
      rd_wb            <= retire && ret_rd_en && (ret_addr != '0);
      retire_wb        <= retire;
      load_timeout_err <= timeout;
      if (retire) pc_wb <= ret_pc;
      // An aborted load wrote nothing, so the last written address/data stay visible.
      if (retire && !timeout) begin
        rd_address_wb <= ret_addr;
        rd_data_wb    <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expected values.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        load_data_valid;
  logic [31:0] load_data;
  logic        flush;
  logic        rd_wb;
  logic [4:0]  rd_address_wb;
  logic [31:0] rd_data_wb;
  logic [31:0] pc_wb;
  logic        retire_wb;
  logic        load_timeout_err;

  int checks   = 0;
  int failures = 0;

  writeback_stage_if #(.WIDTH(32), .REG_ADDR_WIDTH(5)) wb_if ();

  writeback_stage #(.WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_TIMEOUT(15)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem              (wb_if),
    .load_data_valid  (load_data_valid),
    .load_data        (load_data),
    .flush            (flush),
    .rd_wb            (rd_wb),
    .rd_address_wb    (rd_address_wb),
    .rd_data_wb       (rd_data_wb),
    .pc_wb            (pc_wb),
    .retire_wb        (retire_wb),
    .load_timeout_err (load_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rd, input logic [4:0] addr,
                       input wb_kind_t kind, input load_size_t size, input logic sgn,
                       input logic [1:0] off, input logic [31:0] alu);
    wb_if.in_valid       = v;
    wb_if.in_pc          = pc;
    wb_if.in_rd          = rd;
    wb_if.in_rd_address  = addr;
    wb_if.in_kind        = kind;
    wb_if.in_load_size   = size;
    wb_if.in_load_signed = sgn;
    wb_if.in_byte_offset = off;
    wb_if.in_alu_result  = alu;
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    load_data_valid = 1'b0;
    load_data       = '0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_NONE, LS_BYTE, 1'b0, 2'd0, 32'h0);

    // reset values
    #2 rst = 1'b0;
    #1;
    check("rst_rd_wb", 32'(rd_wb), 32'd0);
    check("rst_retire", 32'(retire_wb), 32'd0);
    check("rst_err", 32'(load_timeout_err), 32'd0);
    check("rst_data", rd_data_wb, 32'h0);
    check("rst_pc", pc_wb, 32'h0);
    check("rst_ready", 32'(wb_if.in_ready), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(wb_if.in_ready), 32'd1);
    check("post_rst_retire", 32'(retire_wb), 32'd0);

    // ALU write, then back-to-back sub-word loads with same-cycle data
    drive(1'b1, 32'h100, 1'b1, 5'd5, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h1234);
    tick();
    check("alu_rd_wb", 32'(rd_wb), 32'd1);
    check("alu_addr", 32'(rd_address_wb), 32'd5);
    check("alu_data", rd_data_wb, 32'h0000_1234);
    check("alu_retire", 32'(retire_wb), 32'd1);
    check("alu_pc", pc_wb, 32'h100);

    drive(1'b1, 32'h104, 1'b1, 5'd6, WB_LOAD, LS_BYTE, 1'b1, 2'd2, 32'h0);
    load_data_valid = 1'b1;
    load_data       = 32'h0080_0000;
    tick();
    check("lb_ready", 32'(wb_if.in_ready), 32'd1);
    check("lb_data", rd_data_wb, 32'hFFFF_FF80);
    check("lb_rd_wb", 32'(rd_wb), 32'd1);
    check("lb_addr", 32'(rd_address_wb), 32'd6);

    drive(1'b1, 32'h108, 1'b1, 5'd7, WB_LOAD, LS_BYTE, 1'b0, 2'd2, 32'h0);
    tick();
    check("lbu_data", rd_data_wb, 32'h0000_0080);
    check("lbu_pc", pc_wb, 32'h108);

    drive(1'b1, 32'h10C, 1'b1, 5'd8, WB_LOAD, LS_HALF, 1'b1, 2'd3, 32'h0);
    load_data = 32'h8001_0000;
    tick();
    check("lh_off3_data", rd_data_wb, 32'hFFFF_8001);

    drive(1'b1, 32'h110, 1'b1, 5'd8, WB_LOAD, LS_WORD, 1'b1, 2'd0, 32'h0);
    load_data = 32'h8000_0000;
    tick();
    check("lw_data", rd_data_wb, 32'h8000_0000);

    drive(1'b1, 32'h114, 1'b1, 5'd8, WB_LOAD, LS_BYTE, 1'b0, 2'd3, 32'h0);
    load_data = 32'hA5_00_00_00;
    tick();
    check("lbu_off3_data", rd_data_wb, 32'h0000_00A5);
    load_data_valid = 1'b0;

    // NONE kind retires without writing
    drive(1'b1, 32'h118, 1'b1, 5'd9, WB_NONE, LS_BYTE, 1'b0, 2'd0, 32'h5555);
    tick();
    check("none_retire", 32'(retire_wb), 32'd1);
    check("none_rd_wb", 32'(rd_wb), 32'd0);
    check("none_data", rd_data_wb, 32'h0);

    // register 0 is never written
    drive(1'b1, 32'h11C, 1'b1, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'hDEAD);
    tick();
    check("r0_retire", 32'(retire_wb), 32'd1);
    check("r0_rd_wb", 32'(rd_wb), 32'd0);

    // idle cycle: strobes drop, address/data hold
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h0);
    tick();
    check("idle_retire", 32'(retire_wb), 32'd0);
    check("idle_rd_wb", 32'(rd_wb), 32'd0);
    check("idle_hold_data", rd_data_wb, 32'h0000_DEAD);
    check("idle_hold_pc", pc_wb, 32'h11C);

    // LINK wraps modulo 2^32
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, WB_LINK, LS_BYTE, 1'b0, 2'd0, 32'h0);
    tick();
    check("link_data", rd_data_wb, 32'h0000_0004);
    check("link_addr", 32'(rd_address_wb), 32'd31);
    check("link_rd_wb", 32'(rd_wb), 32'd1);

    // delayed LHU: fields must come from the hold registers
    drive(1'b1, 32'h200, 1'b1, 5'd10, WB_LOAD, LS_HALF, 1'b0, 2'd2, 32'h0);
    tick();
    drive(1'b0, 32'h999, 1'b0, 5'd1, WB_ALU, LS_BYTE, 1'b1, 2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("wait_ready_low", 32'(wb_if.in_ready), 32'd0);
      check("wait_no_retire", 32'(retire_wb), 32'd0);
      if (i == 2) begin
        load_data_valid = 1'b1;
        load_data       = 32'hBEEF_0000;
      end else begin
        tick();
      end
    end
    tick();
    load_data_valid = 1'b0;
    check("dly_data", rd_data_wb, 32'h0000_BEEF);
    check("dly_rd_wb", 32'(rd_wb), 32'd1);
    check("dly_addr", 32'(rd_address_wb), 32'd10);
    check("dly_pc", pc_wb, 32'h200);
    check("dly_ready", 32'(wb_if.in_ready), 32'd1);

    // timeout after 15 waiting cycles
    drive(1'b1, 32'h300, 1'b1, 5'd11, WB_LOAD, LS_WORD, 1'b0, 2'd0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      check("to_wait_ready", 32'(wb_if.in_ready), 32'd0);
      check("to_wait_err", 32'(load_timeout_err), 32'd0);
      tick();
    end
    check("to_err", 32'(load_timeout_err), 32'd1);
    check("to_retire", 32'(retire_wb), 32'd1);
    check("to_rd_wb", 32'(rd_wb), 32'd0);
    check("to_pc", pc_wb, 32'h300);
    check("to_ready", 32'(wb_if.in_ready), 32'd1);
    tick();
    check("to_err_pulse", 32'(load_timeout_err), 32'd0);
    check("to_retire_pulse", 32'(retire_wb), 32'd0);

    // flush in WAIT_LOAD on the same cycle data arrives
    drive(1'b1, 32'h400, 1'b1, 5'd12, WB_LOAD, LS_WORD, 1'b0, 2'd0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h0);
    tick();
    flush           = 1'b1;
    load_data_valid = 1'b1;
    load_data       = 32'h1111_2222;
    tick();
    flush           = 1'b0;
    load_data_valid = 1'b0;
    check("fw_retire", 32'(retire_wb), 32'd0);
    check("fw_rd_wb", 32'(rd_wb), 32'd0);
    check("fw_err", 32'(load_timeout_err), 32'd0);
    check("fw_ready", 32'(wb_if.in_ready), 32'd1);

    // flush in IDLE drops the offered instruction
    drive(1'b1, 32'h500, 1'b1, 5'd13, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h7777);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h0);
    check("fi_retire", 32'(retire_wb), 32'd0);
    check("fi_rd_wb", 32'(rd_wb), 32'd0);
    check("fi_pc_hold", pc_wb, 32'h300);

    // reset during WAIT_LOAD abandons the load
    drive(1'b1, 32'h600, 1'b1, 5'd14, WB_LOAD, LS_WORD, 1'b0, 2'd0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 5'd0, WB_ALU, LS_BYTE, 1'b0, 2'd0, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("mrst_pc", pc_wb, 32'h0);
    check("mrst_ready", 32'(wb_if.in_ready), 32'd0);
    #2 rst = 1'b1;
    load_data_valid = 1'b1;
    load_data       = 32'h3333_4444;
    tick();
    load_data_valid = 1'b0;
    check("mrst_no_retire", 32'(retire_wb), 32'd0);
    check("mrst_no_write", 32'(rd_wb), 32'd0);
    check("mrst_ready_back", 32'(wb_if.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised successor of the combinational writeback mux.
- Registered MEM/WB stage with a valid/ready handshake on its input.
- Absorbs variable-latency load data and extracts sub-word loads (byte, half, word, full) with sign or zero extension.
- Produces link values and drives the register-file write port and retire strobe at the end of the pipeline.

Parameters:
- WIDTH, 32, datapath width; multiple of 32.
- REG_ADDR_WIDTH, 5, register address width.
- LOAD_TIMEOUT, 15, maximum cycles spent in WAIT_LOAD before abort; at least 1.
- OFFSET_W, $clog2(WIDTH/8), byte-offset width. Derived; never overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- in_valid, input, 1, MEM stage presents an instruction.
- in_ready, output, 1, stage can accept; an instruction transfers when in_valid && in_ready.
- in_pc, input, WIDTH, PC of the instruction.
- in_rd, input, 1, instruction writes a register.
- in_rd_address, input, REG_ADDR_WIDTH, destination register.
- in_kind, input, 2, wb_kind_t: NONE=0, ALU=1, LOAD=2, LINK=3.
- in_load_size, input, 2, load_size_t: BYTE=0, HALF=1, WORD=2, FULL=3.
- in_load_signed, input, 1, 1 = sign-extend, 0 = zero-extend.
- in_byte_offset, input, OFFSET_W, address low bits of the load.
- in_alu_result, input, WIDTH, ALU result.
- load_data_valid, input, 1, load_data is valid this cycle.
- load_data, input, WIDTH, raw aligned memory word.
- flush, input, 1, discard any incoming or pending instruction.
- rd_wb, output, 1, register write strobe (one-cycle pulse).
- rd_address_wb, output, REG_ADDR_WIDTH, write address.
- rd_data_wb, output, WIDTH, write data.
- pc_wb, output, WIDTH, PC of the retired instruction.
- retire_wb, output, 1, instruction retired (one-cycle pulse).
- load_timeout_err, output, 1, pulse on load abort.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0; in_ready is 1 once reset is released.
  - State is IDLE, timeout counter is 0, hold registers are 0.
  - Reset asserted mid-WAIT_LOAD abandons the load with no retire.
- States:
  - IDLE: in_ready=1.
  - WAIT_LOAD: in_ready=0.
- IDLE transitions (on accept):
  - kind≠LOAD, or kind=LOAD with load_data_valid in the same cycle: result is registered and appears on outputs next cycle (latency 1); state stays IDLE.
  - kind=LOAD and !load_data_valid: latch pc, rd, address, size, signed, offset into hold registers; clear counter; go to WAIT_LOAD.
- WAIT_LOAD transitions:
  - load_data_valid: retire from hold registers next cycle; go to IDLE.
  - Otherwise the counter increments.
  - Counter reaches LOAD_TIMEOUT: next cycle retire_wb=1, rd_wb=0, load_timeout_err=1, pc_wb=held pc; go to IDLE.
- Flush:
  - flush has priority over accept, load_data_valid and timeout.
  - In IDLE: the offered instruction is not retired.
  - In WAIT_LOAD: return to IDLE; no retire, no error.
  - The cycle after a flush, rd_wb, retire_wb and load_timeout_err are 0.
- Result selection:
  - ALU: in_alu_result.
  - LINK: pc+8, modulo 2^WIDTH.
  - NONE: data 0 and rd_wb=0, but retire_wb=1.
- Load extraction (little-endian lanes):
  - BYTE: byte lane in_byte_offset.
  - HALF: half lane in_byte_offset[OFFSET_W-1:1]; offset bit 0 ignored.
  - WORD: 32-bit lane in_byte_offset[OFFSET_W-1:2].
  - FULL: the whole word.
  - Result is sign- or zero-extended to WIDTH.
  - Misalignment is trapped upstream and not checked here.
- Write strobe:
  - rd_wb = retiring && in_rd && kind≠NONE && rd_address≠0.
  - Register 0 is never written.
- Output timing:
  - rd_wb, retire_wb and load_timeout_err are single-cycle pulses.
  - rd_address_wb, rd_data_wb and pc_wb hold their last retired values between retirements.
- Throughput:
  - One instruction per cycle in IDLE with no bubble.
  - The cycle of WAIT_LOAD exit already has in_ready=1, because the next-state is IDLE and in_ready is driven from the registered state of the following cycle (no combinational ready path from load_data_valid).

Decomposition:
- Add wb_kind_t, load_size_t and LINK_OFFSET=8 to the shared Constants package, alongside WIDTH, BYTE and REG_ADDR_WIDTH.
- Sub-module load_extract: combinational lane select plus extension, parametrised on WIDTH.
- The FSM, counter, hold registers and output registers live in writeback_stage.

Test Plan:
- ALU: in_rd=1, addr 5, alu 0x1234 → next cycle rd_wb=1, addr 5, data 0x00001234, retire_wb=1.
- LB signed: offset 2, load_data 0x00800000, same-cycle valid → rd_data_wb 0xFFFFFF80. LBU gives 0x00000080.
- Delayed load: LHU offset 2; valid after 3 cycles with 0xBEEF0000 → in_ready low for 3 cycles; then rd_data_wb 0x0000BEEF one cycle after valid.
- Timeout (LOAD_TIMEOUT=15): no valid ever arrives → after 15 WAIT cycles, load_timeout_err=1, retire_wb=1, rd_wb=0; in_ready returns to 1.
- LINK: pc 0xFFFFFFFC, addr 31 → rd_data_wb 0x00000004.
- Register 0 and flush:
  - ALU write to addr 0 → retire_wb=1, rd_wb=0.
  - flush raised in the cycle load_data_valid arrives in WAIT_LOAD → no retire; IDLE next.
